banked_data_mem: RTL and testbench



---
 rtl/mem_pkg.sv | 49 ++++
 rtl/lane_align.sv | 46 ++++
 rtl/ram_template.sv | 32 +++
 rtl/banked_data_mem.sv | 177 +++++++++++++++++
 tb/tb_banked_data_mem.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/mem_pkg.sv
// mem_pkg: shared funct3 encodings, access-size and FSM state types for banked_data_mem.
`default_nettype none

package mem_pkg;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LD  = 3'b011;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;
  localparam logic [2:0] LWU = 3'b110;
  localparam logic [2:0] SB  = 3'b000;
  localparam logic [2:0] SH  = 3'b001;
  localparam logic [2:0] SW  = 3'b010;
  localparam logic [2:0] SD  = 3'b011;

  typedef enum logic [1:0] {
    SZ_B = 2'b00,
    SZ_H = 2'b01,
    SZ_W = 2'b10,
    SZ_D = 2'b11
  } mem_size_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RESP = 2'b01,
    ST_HOLD = 2'b10
  } mem_state_e;

  // Byte count of an access; 0 marks the one encoding that is never legal (111).
  function automatic logic [3:0] access_bytes(input logic [2:0] funct3);
    logic [3:0] n;
    case (funct3[1:0])
      2'b00:   n = 4'd1;
      2'b01:   n = 4'd2;
      2'b10:   n = 4'd4;
      default: n = funct3[2] ? 4'd0 : 4'd8;
    endcase
    return n;
  endfunction

  function automatic mem_size_e size_of(input logic [2:0] funct3);
    return mem_size_e'(funct3[1:0]);
  endfunction

endpackage

`default_nettype wire

// File: rtl/lane_align.sv
// lane_align: rotates bank outputs by the access lane and sign/zero-extends to XLEN.
`default_nettype none

module lane_align
  import mem_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int LANE_W = 2
) (
  input  logic [XLEN-1:0]   bank_rdata_i,
  input  logic [LANE_W-1:0] lane_i,
  input  logic [2:0]        funct3_i,
  output logic [XLEN-1:0]   rdata_o
);

  localparam int NB = XLEN / 8;

  logic [XLEN-1:0]   w_rot;
  logic [LANE_W-1:0] w_idx;
  mem_size_e         w_sz;
  logic              w_uns;

  // Byte k of the access lives in bank (lane+k) mod NB; the narrow index wraps for free.
  always_comb begin
    w_rot = '0;
    w_idx = '0;
    for (int k = 0; k < NB; k++) begin
      w_idx = lane_i + LANE_W'(k);
      w_rot[8*k +: 8] = bank_rdata_i[8*w_idx +: 8];
    end
  end

  always_comb begin
    w_sz  = size_of(funct3_i);
    w_uns = funct3_i[2];
    case (w_sz)
      SZ_B:    rdata_o = w_uns ? XLEN'(w_rot[7:0])  : XLEN'($signed(w_rot[7:0]));
      SZ_H:    rdata_o = w_uns ? XLEN'(w_rot[15:0]) : XLEN'($signed(w_rot[15:0]));
      SZ_W:    rdata_o = w_uns ? XLEN'(w_rot[31:0]) : XLEN'($signed(w_rot[31:0]));
      default: rdata_o = w_rot;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/ram_template.sv
// ram_template: single-port read-first synchronous RAM primitive, one bank of the data memory.
`default_nettype none

module ram_template #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  en_i,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [2**ADDR_WIDTH];
  logic [DATA_WIDTH-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (en_i) begin
      rdata_q <= mem_q[addr_i];
      if (we_i) begin
        mem_q[addr_i] <= wdata_i;
      end
    end
  end

  assign rdata_o = rdata_q;

endmodule

`default_nettype wire

// File: rtl/banked_data_mem.sv
// banked_data_mem: byte-banked data RAM with valid/ready request/response and a hold register.
// Option: define BANKED_DATA_MEM_MISALIGN_TRAP_EN to trap misaligned accesses instead of completing them.
`default_nettype none

module banked_data_mem
  import mem_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int RAM_SIZE_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [2:0]            req_funct3,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [XLEN-1:0]       req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [XLEN-1:0]       rsp_rdata,
  output logic                  rsp_fault,
  output logic                  rsp_misaligned
);

  localparam int NB    = XLEN / 8;
  localparam int LNB   = $clog2(NB);
  localparam int ROW_W = RAM_SIZE_WIDTH - LNB;
  localparam logic [RAM_SIZE_WIDTH:0] ONE = (RAM_SIZE_WIDTH+1)'(1);
  localparam logic [ROW_W-1:0]        ROW_ONE = ROW_W'(1);

  mem_state_e        state_q;
  logic              valid_q;
  logic              fault_q;
  logic              mis_q;
  logic              zero_q;
  logic [2:0]        funct3_q;
  logic [LNB-1:0]    lane_q;
  logic [XLEN-1:0]   hold_q;

  logic [LNB-1:0]            w_lane;
  logic [ROW_W-1:0]          w_row;
  logic [ROW_W-1:0]          w_row_inc;
  logic [3:0]                w_size;
  logic [RAM_SIZE_WIDTH:0]   w_last;
  logic                      w_illegal;
  logic                      w_oob;
  logic                      w_fault;
  logic                      w_mis;
  logic                      w_accept;
  logic                      w_bank_we;
  logic [XLEN-1:0]           w_bank_rdata;
  logic [XLEN-1:0]           w_aligned;
  logic [XLEN-1:0]           w_fmt;

  assign w_lane    = req_addr[LNB-1:0];
  assign w_row     = req_addr[RAM_SIZE_WIDTH-1:LNB];
  assign w_row_inc = w_row + ROW_ONE;
  assign w_size    = access_bytes(req_funct3);

  // Last byte computed one bit wider so that running off the top is visible as a carry.
  assign w_last    = {1'b0, req_addr[RAM_SIZE_WIDTH-1:0]} + (RAM_SIZE_WIDTH+1)'(w_size) - ONE;
  assign w_illegal = (w_size == 4'd0) ||
                     ((XLEN == 32) && ((req_funct3 == LD) || (req_funct3 == LWU)));
  assign w_oob     = (req_addr[ADDR_WIDTH-1:RAM_SIZE_WIDTH] != '0) || w_last[RAM_SIZE_WIDTH];
  assign w_fault   = w_illegal || w_oob;

`ifdef BANKED_DATA_MEM_MISALIGN_TRAP_EN
  assign w_mis = !w_fault && ((req_addr[3:0] & (w_size - 4'd1)) != 4'd0);
`else
  assign w_mis = 1'b0;
`endif

  assign req_ready = (state_q == ST_IDLE) || ((state_q == ST_RESP) && rsp_ready);
  assign w_accept  = req_valid && req_ready;
  assign w_bank_we = w_accept && req_write && !w_fault && !w_mis;

  for (genvar b = 0; b < NB; b++) begin : g_bank
    logic [LNB-1:0]   w_k;
    logic [ROW_W-1:0] w_addr;
    logic             w_we;

    // Banks below the start lane hold the wrapped tail of the access in the next row.
    assign w_k    = LNB'(b) - w_lane;
    assign w_addr = (LNB'(b) < w_lane) ? w_row_inc : w_row;
    assign w_we   = w_bank_we && ({{(4-LNB){1'b0}}, w_k} < w_size);

    ram_template #(
      .DATA_WIDTH(8),
      .ADDR_WIDTH(ROW_W)
    ) u_ram (
      .clk    (clk),
      .en_i   (w_accept),
      .we_i   (w_we),
      .addr_i (w_addr),
      .wdata_i(req_wdata[8*w_k +: 8]),
      .rdata_o(w_bank_rdata[8*b +: 8])
    );
  end

  lane_align #(
    .XLEN  (XLEN),
    .LANE_W(LNB)
  ) u_lane_align (
    .bank_rdata_i(w_bank_rdata),
    .lane_i      (lane_q),
    .funct3_i    (funct3_q),
    .rdata_o     (w_aligned)
  );

  assign w_fmt = zero_q ? '0 : w_aligned;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      valid_q  <= 1'b0;
      fault_q  <= 1'b0;
      mis_q    <= 1'b0;
      zero_q   <= 1'b0;
      funct3_q <= 3'b000;
      lane_q   <= '0;
      hold_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (w_accept) begin
            state_q <= ST_RESP;
            valid_q <= 1'b1;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            if (!w_accept) begin
              state_q <= ST_IDLE;
              valid_q <= 1'b0;
              fault_q <= 1'b0;
              mis_q   <= 1'b0;
            end
          end else begin
            hold_q  <= w_fmt;
            state_q <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (rsp_ready) begin
            state_q <= ST_IDLE;
            valid_q <= 1'b0;
            fault_q <= 1'b0;
            mis_q   <= 1'b0;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          valid_q <= 1'b0;
        end
      endcase

      if (w_accept) begin
        fault_q  <= w_fault;
        mis_q    <= w_mis;
        zero_q   <= req_write || w_fault || w_mis;
        funct3_q <= req_funct3;
        lane_q   <= w_lane;
      end
    end
  end

  assign rsp_valid      = valid_q;
  assign rsp_fault      = fault_q;
  assign rsp_misaligned = mis_q;
  assign rsp_rdata      = (state_q == ST_HOLD) ? hold_q :
                          (state_q == ST_RESP) ? w_fmt  : '0;

endmodule

`default_nettype wire

// File: tb/tb_banked_data_mem.sv
// tb_banked_data_mem: directed self-checking bench for banked_data_mem at XLEN=32.
`default_nettype none

module tb_banked_data_mem;
  import mem_pkg::*;

`ifdef BANKED_DATA_MEM_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_fault;
  logic        rsp_misaligned;

  int n_checks = 0;
  int n_errors = 0;

  banked_data_mem #(
    .XLEN(32),
    .ADDR_WIDTH(32),
    .RAM_SIZE_WIDTH(16)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_write     (req_write),
    .req_funct3    (req_funct3),
    .req_addr      (req_addr),
    .req_wdata     (req_wdata),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_rdata     (rsp_rdata),
    .rsp_fault     (rsp_fault),
    .rsp_misaligned(rsp_misaligned)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic w, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
    req_valid  = 1'b1;
    req_write  = w;
    req_funct3 = f3;
    req_addr   = a;
    req_wdata  = d;
  endtask

  task automatic idle_req();
    req_valid = 1'b0;
    req_write = 1'b0;
  endtask

  task automatic expect_rsp(input string tag, input logic [31:0] rd, input logic flt, input logic mis);
    chk({tag, ".valid"}, 32'(rsp_valid), 32'd1);
    chk({tag, ".rdata"}, rsp_rdata, rd);
    chk({tag, ".fault"}, 32'(rsp_fault), 32'(flt));
    chk({tag, ".mis"}, 32'(rsp_misaligned), 32'(mis));
  endtask

  // One request with the consumer always ready; response checked in the following cycle.
  task automatic single(input string tag, input logic w, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] d, input logic [31:0] rd, input logic flt, input logic mis);
    @(negedge clk);
    rsp_ready = 1'b1;
    drive(w, f3, a, d);
    chk({tag, ".ready"}, 32'(req_ready), 32'd1);
    @(negedge clk);
    idle_req();
    expect_rsp(tag, rd, flt, mis);
  endtask

  logic [2:0]  b2b_f3  [4];
  logic [31:0] b2b_a   [4];
  logic [31:0] b2b_exp [4];

  initial begin
    b2b_f3  = '{LW, LBU, LH, LHU};
    b2b_a   = '{32'h100, 32'h101, 32'h102, 32'h100};
    b2b_exp = '{32'hDEADBEEF, 32'h000000BE, 32'hFFFFDEAD, 32'h0000BEEF};

    rst_n = 1'b0; rsp_ready = 1'b1;
    req_valid = 1'b0; req_write = 1'b0; req_funct3 = 3'b000; req_addr = '0; req_wdata = '0;
    repeat (2) @(negedge clk);
    chk("rst.valid", 32'(rsp_valid), 32'd0);
    chk("rst.fault", 32'(rsp_fault), 32'd0);
    chk("rst.mis", 32'(rsp_misaligned), 32'd0);
    chk("rst.rdata", rsp_rdata, 32'd0);
    chk("rst.ready", 32'(req_ready), 32'd1);
    rst_n = 1'b1;

    // Basic word store and extended loads
    single("sw100",  1'b1, SW,  32'h100, 32'hDEADBEEF, 32'h0,        1'b0, 1'b0);
    single("lw100",  1'b0, LW,  32'h100, 32'h0,        32'hDEADBEEF, 1'b0, 1'b0);
    single("lb100",  1'b0, LB,  32'h100, 32'h0,        32'hFFFFFFEF, 1'b0, 1'b0);
    single("lbu100", 1'b0, LBU, 32'h100, 32'h0,        32'h000000EF, 1'b0, 1'b0);
    single("lh102",  1'b0, LH,  32'h102, 32'h0,        32'hFFFFDEAD, 1'b0, 1'b0);
    single("lhu102", 1'b0, LHU, 32'h102, 32'h0,        32'h0000DEAD, 1'b0, 1'b0);
    single("lb103",  1'b0, LB,  32'h103, 32'h0,        32'hFFFFFFDE, 1'b0, 1'b0);

    // Misaligned word across a row boundary
    single("sb1ff",  1'b1, SB,  32'h1FF, 32'h5A,       32'h0, 1'b0, 1'b0);
    single("sb200",  1'b1, SB,  32'h200, 32'h6B,       32'h0, 1'b0, 1'b0);
    single("swmis",  1'b1, SW,  32'h1FF, 32'h11223344, 32'h0, 1'b0, TRAP);
    single("lwmis",  1'b0, LW,  32'h1FF, 32'h0, TRAP ? 32'h0 : 32'h11223344, 1'b0, TRAP);
    single("lbu1ff", 1'b0, LBU, 32'h1FF, 32'h0, TRAP ? 32'h5A : 32'h44, 1'b0, 1'b0);
    single("lbu200", 1'b0, LBU, 32'h200, 32'h0, TRAP ? 32'h6B : 32'h33, 1'b0, 1'b0);
    single("lhmis",  1'b0, LH,  32'h201, 32'h0, TRAP ? 32'h0 : 32'h00001122, 1'b0, TRAP);

    // Bounds and funct3 faults
    single("swtop",  1'b1, SW,  32'hFFFC, 32'hCAFEF00D, 32'h0, 1'b0, 1'b0);
    single("sbtop",  1'b1, SB,  32'hFFFF, 32'h80,       32'h0, 1'b0, 1'b0);
    single("lwtop",  1'b0, LW,  32'hFFFC, 32'h0, 32'h80FEF00D, 1'b0, 1'b0);
    single("lbtop",  1'b0, LB,  32'hFFFF, 32'h0, 32'hFFFFFF80, 1'b0, 1'b0);
    single("lwoob",  1'b0, LW,  32'hFFFD, 32'h0, 32'h0, 1'b1, 1'b0);
    single("sb0",    1'b1, SB,  32'h0,    32'h12, 32'h0, 1'b0, 1'b0);
    single("sbhi",   1'b1, SB,  32'h10000, 32'h99, 32'h0, 1'b1, 1'b0);
    single("lbu0",   1'b0, LBU, 32'h0,    32'h0, 32'h12, 1'b0, 1'b0);
    single("ld32",   1'b0, LD,  32'h100,  32'h0, 32'h0, 1'b1, 1'b0);
    single("lwu32",  1'b0, LWU, 32'h100,  32'h0, 32'h0, 1'b1, 1'b0);
    single("f3_111", 1'b0, 3'b111, 32'h100, 32'h0, 32'h0, 1'b1, 1'b0);

    // Backpressure: three cycles with the consumer stalled
    @(negedge clk);
    rsp_ready = 1'b0;
    drive(1'b0, LW, 32'h100, 32'h0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      idle_req();
      chk($sformatf("bp%0d.valid", i), 32'(rsp_valid), 32'd1);
      chk($sformatf("bp%0d.rdata", i), rsp_rdata, 32'hDEADBEEF);
      chk($sformatf("bp%0d.ready", i), 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    #1;
    chk("bp.holdblk", 32'(req_ready), 32'd0);
    @(negedge clk);
    chk("bp.release", 32'(rsp_valid), 32'd0);
    chk("bp.idle", 32'(req_ready), 32'd1);

    // Back-to-back loads, one per cycle
    drive(1'b0, b2b_f3[0], b2b_a[0], 32'h0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("b2b%0d.valid", i), 32'(rsp_valid), 32'd1);
      chk($sformatf("b2b%0d.rdata", i), rsp_rdata, b2b_exp[i]);
      if (i < 3) begin
        chk($sformatf("b2b%0d.ready", i), 32'(req_ready), 32'd1);
        drive(1'b0, b2b_f3[i+1], b2b_a[i+1], 32'h0);
      end else begin
        idle_req();
      end
    end

    // Store immediately followed by a load of the same halfword
    @(negedge clk);
    drive(1'b1, SH, 32'h22, 32'hBEEF);
    @(negedge clk);
    chk("raw.st.valid", 32'(rsp_valid), 32'd1);
    chk("raw.st.rdata", rsp_rdata, 32'h0);
    drive(1'b0, LH, 32'h22, 32'h0);
    @(negedge clk);
    idle_req();
    chk("raw.ld.valid", 32'(rsp_valid), 32'd1);
    chk("raw.ld.rdata", rsp_rdata, 32'hFFFFBEEF);

    // Reset while a response is held
    @(negedge clk);
    rsp_ready = 1'b0;
    drive(1'b0, LW, 32'h100, 32'h0);
    @(negedge clk);
    idle_req();
    @(negedge clk);
    chk("rh.held", 32'(rsp_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rh.valid", 32'(rsp_valid), 32'd0);
    chk("rh.rdata", rsp_rdata, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    single("rh.lw", 1'b0, LW, 32'h100, 32'h0, 32'hDEADBEEF, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
